diff_unit_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational diff unit in the KGP_RISC execute stage.
- Compares two WIDTH-bit operands over x = a ^ b and returns one of three results, selected by mode:
  - index of the least-significant differing bit;
  - index of the most-significant differing bit;
  - Hamming distance (popcount of x).
- Scans x CHUNK bits per cycle behind a start/done handshake, so wide operands do not sit on the ALU critical path.

---
 rtl/diff_pkg.sv | 20 ++
 rtl/diff_unit_seq_if.sv | 34 +++
 rtl/diff_chunk_enc.sv | 49 ++++
 rtl/diff_unit_seq.sv | 167 ++++++++++++++++
 tb/tb_diff_unit_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/diff_pkg.sv
// ---------------------------------------------------------------------------
// diff_pkg
//   Shared definitions for the sequential diff unit: result-mode encodings and
//   the FSM state encoding used by diff_unit_seq.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package diff_pkg;

  // Result selection. 2'b11 is reserved and behaves like MODE_LSB.
  localparam logic [1:0] MODE_LSB = 2'b00;
  localparam logic [1:0] MODE_MSB = 2'b01;
  localparam logic [1:0] MODE_POP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/diff_unit_seq_if.sv
// ---------------------------------------------------------------------------
// diff_unit_seq_if
//   Request/result bundle of the sequential diff unit.
//   master: drives start, mode, a, b; observes ready, busy, done, out,
//           diff_zero.
//   slave : the diff unit itself (opposite directions).
// ---------------------------------------------------------------------------
interface diff_unit_seq_if #(
  parameter int WIDTH = 32
) ();

  localparam int OUTW = $clog2(WIDTH) + 1;

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [OUTW-1:0]  out;
  logic             diff_zero;

  modport master (
    output start, mode, a, b,
    input  ready, busy, done, out, diff_zero
  );

  modport slave (
    input  start, mode, a, b,
    output ready, busy, done, out, diff_zero
  );

endinterface

// File: rtl/diff_chunk_enc.sv
// ---------------------------------------------------------------------------
// diff_chunk_enc
//   Combinational encoder for one CHUNK-bit slice of the difference vector.
//   chunk   in   CHUNK        slice under examination
//   nz      out  1            slice has at least one set bit
//   lsb_idx out  log2(CHUNK)  position of lowest set bit (0 when nz=0)
//   msb_idx out  log2(CHUNK)  position of highest set bit (0 when nz=0)
//   pop     out  log2(CHUNK)+1 number of set bits
//   CHUNK must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module diff_chunk_enc #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]         chunk,
  output logic                     nz,
  output logic [$clog2(CHUNK)-1:0] lsb_idx,
  output logic [$clog2(CHUNK)-1:0] msb_idx,
  output logic [$clog2(CHUNK):0]   pop
);

  localparam int IW = $clog2(CHUNK);
  localparam int PW = IW + 1;

  // Priority encode both ends and count set bits of the slice.
  always_comb begin
    nz      = |chunk;
    lsb_idx = '0;
    msb_idx = '0;
    pop     = '0;
    // Walking downward, the last hit written is the lowest set bit.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        lsb_idx = IW'(i);
      end else begin
        lsb_idx = lsb_idx;
      end
    end
    // Walking upward, the last hit written is the highest set bit.
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        msb_idx = IW'(i);
      end else begin
        msb_idx = msb_idx;
      end
      pop = pop + PW'(chunk[i]);
    end
  end

endmodule

// File: rtl/diff_unit_seq.sv
// ---------------------------------------------------------------------------
// diff_unit_seq
//   Multi-cycle diff unit. On an accepted start it latches x = a ^ b and mode,
//   then scans x one CHUNK per clock to produce the LSB index, MSB index or
//   popcount of x. Index modes exit early on the first nonzero chunk.
//   clk  in  system clock (rising edge)
//   rst  in  synchronous active-high reset; aborts any operation in flight
//   bus  slave modport of diff_unit_seq_if:
//        start/mode/a/b in; ready/busy/done/out/diff_zero out (all registered)
// ---------------------------------------------------------------------------
module diff_unit_seq
  import diff_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  diff_unit_seq_if.slave  bus
);

  localparam int OUTW   = $clog2(WIDTH) + 1;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = $clog2(CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_STEP = KW'(NCHUNK - 1);

  state_t           state_r;
  logic [WIDTH-1:0] x_r;
  logic [1:0]       mode_r;
  logic [KW-1:0]    step_r;
  logic [OUTW-1:0]  acc_r;
  logic [OUTW-1:0]  out_r;
  logic             zero_r;
  logic             done_r;
  logic             busy_r;
  logic             ready_r;

  logic             is_msb_s;
  logic             is_pop_s;
  logic             last_s;
  logic [KW-1:0]    chunk_idx_s;
  logic [OUTW-1:0]  base_s;
  logic [CHUNK-1:0] chunk_s;
  logic             nz_s;
  logic [IW-1:0]    lsb_idx_s;
  logic [IW-1:0]    msb_idx_s;
  logic [IW:0]      pop_s;
  logic [OUTW-1:0]  hit_idx_s;
  logic [OUTW-1:0]  acc_next_s;

  // Select the chunk for this step; MSB mode walks from the top chunk down.
  always_comb begin
    is_msb_s = (mode_r == MODE_MSB);
    is_pop_s = (mode_r == MODE_POP);
    last_s   = (step_r == LAST_STEP);
    if (is_msb_s) begin
      chunk_idx_s = LAST_STEP - step_r;
    end else begin
      chunk_idx_s = step_r;
    end
    base_s  = OUTW'(chunk_idx_s) * OUTW'(CHUNK);
    chunk_s = CHUNK'(x_r >> base_s);
  end

  diff_chunk_enc #(
    .CHUNK (CHUNK)
  ) u_enc (
    .chunk   (chunk_s),
    .nz      (nz_s),
    .lsb_idx (lsb_idx_s),
    .msb_idx (msb_idx_s),
    .pop     (pop_s)
  );

  // Turn the in-chunk hit position into an absolute index; extend the count.
  always_comb begin
    if (is_msb_s) begin
      hit_idx_s = base_s + OUTW'(msb_idx_s);
    end else begin
      hit_idx_s = base_s + OUTW'(lsb_idx_s);
    end
    acc_next_s = acc_r + OUTW'(pop_s);
  end

  // Control FSM with step counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      x_r     <= '0;
      mode_r  <= MODE_LSB;
      step_r  <= '0;
      acc_r   <= '0;
      out_r   <= '0;
      zero_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            // out_r deliberately untouched: the old result stays visible.
            x_r     <= bus.a ^ bus.b;
            mode_r  <= bus.mode;
            step_r  <= '0;
            acc_r   <= '0;
            zero_r  <= 1'b0;
            state_r <= SCAN;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        SCAN: begin
          if (is_pop_s) begin
            acc_r <= acc_next_s;
            if (last_s) begin
              out_r   <= acc_next_s;
              zero_r  <= (acc_next_s == '0);
              state_r <= DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              ready_r <= 1'b1;
            end else begin
              step_r <= step_r + KW'(1);
            end
          end else if (nz_s) begin
            out_r   <= hit_idx_s;
            zero_r  <= 1'b0;
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else if (last_s) begin
            out_r   <= '0;
            zero_r  <= 1'b1;
            state_r <= DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            step_r <= step_r + KW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.out       = out_r;
  assign bus.diff_zero = zero_r;

endmodule

// File: tb/tb_diff_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_diff_unit_seq
//   Self-checking bench for diff_unit_seq (WIDTH=32, CHUNK=8): directed
//   vectors, randomized operations against a bit-loop reference model, and
//   handshake / reset scenarios.
// ---------------------------------------------------------------------------
module tb_diff_unit_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int OUTW  = 6;
  localparam int NCH   = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  diff_unit_seq_if #(.WIDTH(WIDTH)) bus ();

  diff_unit_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Directed table: a, b, mode, expected out, expected diff_zero, latency.
  localparam int ND = 12;
  logic [31:0] d_a    [ND] = '{32'h140, 32'h140, 32'h140, 32'h140,
                               32'h80000000, 32'h80000000, 32'h1, 32'h1,
                               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                               32'hFFFFFFFF};
  logic [31:0] d_b    [ND] = '{32'h0C0, 32'h0C0, 32'h0C0, 32'h0C0,
                               32'h0, 32'h0, 32'h2, 32'h2,
                               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                               32'h0};
  logic [1:0]  d_mode [ND] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0,
                               2'd2, 2'd0, 2'd2, 2'd1, 2'd2};
  int          d_out  [ND] = '{7, 8, 2, 7, 31, 31, 0, 2, 0, 0, 0, 32};
  logic        d_zero [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  int          d_lat  [ND] = '{2, 4, 5, 2, 5, 2, 2, 5, 5, 5, 5, 5};

  // Reference: walk x bit by bit, then derive result and done latency.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] mode, output int e_out,
                       output logic e_zero, output int e_lat);
    logic [31:0] x;
    int first;
    int last;
    int cnt;
    x = a ^ b;
    first = -1;
    last = -1;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    if (mode == 2'd2) begin
      e_out = cnt; e_zero = (cnt == 0); e_lat = NCH + 1;
    end else if (x == 32'd0) begin
      e_out = 0; e_zero = 1'b1; e_lat = NCH + 1;
    end else if (mode == 2'd1) begin
      e_out = last; e_zero = 1'b0; e_lat = (NCH - 1 - last / CHUNK) + 2;
    end else begin
      e_out = first; e_zero = 1'b0; e_lat = first / CHUNK + 2;
    end
  endtask

  // Present a request in the cycle before an edge; returns #1 after that edge
  // with start dropped and the operand inputs scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mode);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.mode = mode;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.mode = 2'($urandom_range(3));
  endtask

  // Count edges until done is seen (bounded); lat is the edge count.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 32'h1;
    bus.b = 32'h0;
    bus.mode = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
    checks++; if (bus.out !== 6'd0) begin errors++; $display("FAIL reset out: got %0d want 0", bus.out); end
    checks++; if (bus.diff_zero !== 1'b0) begin errors++; $display("FAIL reset diff_zero: got %b want 0", bus.diff_zero); end
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL reset idle: busy %b ready %b want 0 1", bus.busy, bus.ready); end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < ND; i++) begin
      start_op(d_a[i], d_b[i], d_mode[i]);
      wait_done(1, lat);
      checks++; if (lat != d_lat[i]) begin errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, d_lat[i]); end
      checks++; if (bus.out !== OUTW'(d_out[i])) begin errors++; $display("FAIL directed[%0d] out: got %0d want %0d", i, bus.out, d_out[i]); end
      checks++; if (bus.diff_zero !== d_zero[i]) begin errors++; $display("FAIL directed[%0d] diff_zero: got %b want %b", i, bus.diff_zero, d_zero[i]); end
      @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL directed[%0d] pulse: done %b ready %b want 0 1", i, bus.done, bus.ready); end
      checks++; if (bus.out !== OUTW'(d_out[i])) begin errors++; $display("FAIL directed[%0d] hold: got %0d want %0d", i, bus.out, d_out[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    int sel;
    int e_out;
    logic e_zero;
    int e_lat;
    int lat;
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      sel = $urandom_range(3);
      case (sel)
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(31));
        2: b = a ^ ($urandom & $urandom & $urandom);
        default: b = $urandom;
      endcase
      mode = 2'($urandom_range(3));
      model(a, b, mode, e_out, e_zero, e_lat);
      start_op(a, b, mode);
      checks++; if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL random[%0d] busy: busy %b ready %b want 1 0", n, bus.busy, bus.ready); end
      wait_done(1, lat);
      checks++; if (lat != e_lat) begin errors++; $display("FAIL random[%0d] latency: got %0d want %0d (a=%h b=%h m=%0d)", n, lat, e_lat, a, b, mode); end
      checks++; if (bus.out !== OUTW'(e_out)) begin errors++; $display("FAIL random[%0d] out: got %0d want %0d (a=%h b=%h m=%0d)", n, bus.out, e_out, a, b, mode); end
      checks++; if (bus.diff_zero !== e_zero) begin errors++; $display("FAIL random[%0d] diff_zero: got %b want %b", n, bus.diff_zero, e_zero); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start_op(32'hFFFF0000, 32'h0, 2'd2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h0;
    bus.b = 32'hFFFFFFFF;
    bus.mode = 2'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(2, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL busy_start latency: got %0d want 5", lat); end
    checks++; if (bus.out !== 6'd16) begin errors++; $display("FAIL busy_start out: got %0d want 16", bus.out); end
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL busy_start queued: busy %b done %b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'h00010000, 32'h0, 2'd0);
    wait_done(1, lat);
    checks++; if (lat != 4 || bus.out !== 6'd16) begin errors++; $display("FAIL b2b first: out %0d lat %0d want 16 4", bus.out, lat); end
    start_op(32'h0000000F, 32'h0, 2'd2);
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b bubble: busy %b done %b want 1 0", bus.busy, bus.done); end
    checks++; if (bus.out !== 6'd16) begin errors++; $display("FAIL b2b hold: got %0d want 16", bus.out); end
    wait_done(1, lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL b2b latency: got %0d want 5", lat); end
    checks++; if (bus.out !== 6'd4) begin errors++; $display("FAIL b2b out: got %0d want 4", bus.out); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    int seen;
    start_op(32'hFFFFFFFF, 32'h0, 2'd2);
    wait_done(1, lat);
    checks++; if (bus.out !== 6'd32) begin errors++; $display("FAIL rst_scan setup out: got %0d want 32", bus.out); end
    @(posedge clk);
    #1;
    start_op(32'h3, 32'h0, 2'd2);
    checks++; if (bus.out !== 6'd32 || bus.diff_zero !== 1'b0) begin errors++; $display("FAIL rst_scan hold: out %0d dz %b want 32 0", bus.out, bus.diff_zero); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_scan state: ready %b busy %b want 1 0", bus.ready, bus.busy); end
    checks++; if (bus.out !== 6'd0) begin errors++; $display("FAIL rst_scan out: got %0d want 0", bus.out); end
    seen = (bus.done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_scan done: got %0d pulses want 0", seen); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    bus.mode = 2'd0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
